dem_uart_tx: RTL
================

# dem_uart_tx

Serializing UART transmitter for the debug UART path. Drains bytes from the upstream single-clock standard FIFO through its read port (`rd_en`, `empty`, `dout` valid one cycle after a read) and shifts each one out on `tx` as an 8N1/8N2 frame at a fixed clock-per-bit divisor. Sits directly downstream of the TX FIFO and drives the UART pin.

## Interface
- `WIDTH`, default 8: data bits per frame; must match the FIFO `WIDTH`.
- `BAUD_DIV`, default 868: clock cycles per bit (100 MHz / 115200). Must be ≥ 2; elaboration fails with `$fatal` otherwise.
- `STOP_BITS`, default 1: stop bits per frame. Legal values are 1 and 2; elaboration fails with `$fatal` otherwise.

- `clk`  in  1: clock. One clock domain.
- `rst`  in  1: reset, asynchronous and active-high.
- `fifo_dout`  in  WIDTH: FIFO read data, valid in the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: FIFO read strobe, one-cycle pulse.
- `tx`  out  1: serial output, idle high.
- `busy`  out  1: high while a frame is being fetched or sent.

## Operation
- States: IDLE, LOAD, START, DATA, STOP.
- `fifo_rd_en` = (state==IDLE) & ~`fifo_empty` & ~`rst`. It is combinational, at most one pulse per frame, and never asserted outside IDLE.
- IDLE: `tx`=1. If `fifo_empty`=0, pulse `fifo_rd_en` and go to LOAD.
- LOAD (one cycle): capture `fifo_dout` into the shift register, clear the baud counter, set `tx`<=0, go to START.
- START: hold `tx`=0 for BAUD_DIV cycles.
- DATA: send WIDTH bits, LSB first, BAUD_DIV cycles each. Shift right at each bit boundary. Bit counter width is $clog2(WIDTH+1).
- STOP: hold `tx`=1 for STOP_BITS×BAUD_DIV cycles, then go to IDLE.
- Baud counter: width $clog2(BAUD_DIV). It counts 0..BAUD_DIV-1 and wraps to 0 at each bit boundary.
- `busy` = (state != IDLE).
- `fifo_empty` and `fifo_dout` are ignored outside IDLE and LOAD.
- Reset values: state IDLE, `tx`=1, `busy`=0, `fifo_rd_en`=0, counters 0, shift register 0.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronously). The in-flight byte is discarded and is not re-read. The next frame starts normally after `rst` deasserts.
- `tx` is a register output (glitch-free pin).

## Timing
- Cycle T: IDLE with `fifo_empty`=0, so `fifo_rd_en`=1.
- T+1: LOAD; `fifo_dout` is captured.
- Start bit occupies cycles T+2 .. T+1+BAUD_DIV.
- Data bit i (0-based) occupies cycles T+2+(i+1)·BAUD_DIV onward, for BAUD_DIV cycles.
- Stop bit(s) start at T+2+(WIDTH+1)·BAUD_DIV.
- IDLE is re-entered at cycle T+2+(1+WIDTH+STOP_BITS)·BAUD_DIV. If the FIFO is not empty, the next `fifo_rd_en` fires in that same cycle.
- Back-to-back frame period is (1+WIDTH+STOP_BITS)·BAUD_DIV + 2 cycles. The extra 2 cycles are idle-high line time.
- `busy` rises at T+1 and falls when IDLE is re-entered.

## Test plan
- **Single byte, 8N1:** BAUD_DIV=4, FIFO holds 0xA5.
  - `fifo_rd_en` pulses once.
  - `tx` sequence, 4 cycles each: 0 | 1,0,1,0,0,1,0,1 | 1.
  - `busy` is high for 41 cycles, and IDLE is re-entered 42 cycles after the `fifo_rd_en` cycle.
- **Back-to-back bytes:** BAUD_DIV=4, FIFO holds 0x00 then 0xFF.
  - `fifo_rd_en` pulses are exactly 42 cycles apart.
  - Frame 1 data bits are all 0; frame 2 data bits are all 1.
  - `tx`=1 for 6 cycles between the two start bits (4 stop + IDLE + LOAD).
- **Empty FIFO:** `fifo_empty`=1 for 100 cycles.
  - `fifo_rd_en`=0, `tx`=1 and `busy`=0 throughout.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0x5A.
  - `tx`=1 and `busy`=0 in the same cycle.
  - After release with FIFO holding 0x3C: exactly one complete, correct frame for 0x3C follows.
- **Two stop bits:** STOP_BITS=2, BAUD_DIV=4, two queued bytes.
  - Stop phase lasts 8 cycles.
  - `fifo_rd_en` pulses are 46 cycles apart.
- **Input noise during frame:** toggle `fifo_empty` and change `fifo_dout` every cycle during a frame of 0xC3.
  - The frame still carries 0xC3.
  - No extra `fifo_rd_en` pulse occurs before IDLE.

Source files
------------

// File: rtl/dem_uart_tx.sv
// Debug UART transmitter: pulls bytes from the TX FIFO read port and
// serializes them as 8N1/8N2 frames at a fixed clocks-per-bit divisor.
module dem_uart_tx #(
    parameter int WIDTH     = 8,
    parameter int BAUD_DIV  = 868,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy
);

    if (BAUD_DIV < 2) begin : g_bad_div
        $fatal(1, "dem_uart_tx: BAUD_DIV must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "dem_uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIT_W-1:0]   bit_q;
    logic [WIDTH-1:0]   shift_q;
    logic               tx_q;
    logic               bit_end;

    assign bit_end    = (cnt_q == CNT_MAX);
    assign fifo_rd_en = (state_q == S_IDLE) & ~fifo_empty & ~rst;
    assign busy       = (state_q != S_IDLE);
    assign tx         = tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!fifo_empty) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_q <= fifo_dout;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b0;
                    state_q <= S_START;
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == LAST_DATA) begin
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // bit_q doubles as the stop-bit index here
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == LAST_STOP) begin
                            bit_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
